// File: rtl/dmem_ctrl.sv
// Line-granular main-memory controller behind the data cache: serves one fill or writeback
// at a time with a fixed latency, plus one parked read and one parked write. Optional
// completion counters are enabled with DMEM_CTRL_STATS_EN.
module dmem_ctrl #(
    parameter int WORD_SIZE   = 32,
    parameter int LINE_SIZE   = 128,
    parameter int MEM_LINES   = 256,
    parameter int MEM_LATENCY = 5
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 mem_req,
    input  logic [WORD_SIZE-1:0] mem_req_addr,
    input  logic                 mem_write,
    input  logic [WORD_SIZE-1:0] mem_write_addr,
    input  logic [LINE_SIZE-1:0] mem_write_data,
    output logic                 mem_res,
    output logic [WORD_SIZE-1:0] mem_res_addr,
    output logic [LINE_SIZE-1:0] mem_res_data,
    output logic                 busy,
    output logic                 err
`ifdef DMEM_CTRL_STATS_EN
    ,
    output logic [31:0]          rd_count,
    output logic [31:0]          wr_count
`endif
);

    localparam int OFF   = $clog2(LINE_SIZE / 8);
    localparam int IDX_W = $clog2(MEM_LINES);
    localparam int LAT_W = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
    localparam logic [LAT_W-1:0] LAT_INIT = LAT_W'(MEM_LATENCY - 1);
    localparam logic [LAT_W-1:0] LAT_ZERO = {LAT_W{1'b0}};

    typedef enum logic [1:0] {IDLE = 2'd0, RD = 2'd1, WR = 2'd2} state_t;
    typedef enum logic [2:0] {SRC_NONE = 3'd0, SRC_PWR = 3'd1, SRC_WR = 3'd2,
                              SRC_PRD = 3'd3, SRC_RD = 3'd4} src_t;

    function automatic logic [IDX_W-1:0] line_idx(input logic [WORD_SIZE-1:0] addr);
        return addr[OFF +: IDX_W];
    endfunction

    function automatic logic [WORD_SIZE-1:0] line_align(input logic [WORD_SIZE-1:0] addr);
        return {addr[WORD_SIZE-1:OFF], {OFF{1'b0}}};
    endfunction

    logic [LINE_SIZE-1:0] mem_r [MEM_LINES];

    state_t               state_r, state_nxt_s;
    logic [LAT_W-1:0]     lat_r, lat_nxt_s;
    logic [WORD_SIZE-1:0] op_addr_r, op_addr_nxt_s;
    logic [LINE_SIZE-1:0] op_data_r, op_data_nxt_s;
    logic                 pend_rd_v_r, pend_rd_v_nxt_s;
    logic [WORD_SIZE-1:0] pend_rd_addr_r, pend_rd_addr_nxt_s;
    logic                 pend_wr_v_r, pend_wr_v_nxt_s;
    logic [WORD_SIZE-1:0] pend_wr_addr_r, pend_wr_addr_nxt_s;
    logic [LINE_SIZE-1:0] pend_wr_data_r, pend_wr_data_nxt_s;
    logic                 err_r, err_nxt_s;
    logic                 mem_res_r;
    logic [WORD_SIZE-1:0] mem_res_addr_r;
    logic [LINE_SIZE-1:0] mem_res_data_r;

    src_t                 src_s;
    logic                 done_s, can_acc_s, rd_merge_s, rd_in_s;
    logic                 wr_park_s, wr_drop_s, rd_park_s, rd_drop_s;
    logic                 wr_commit_s, res_fire_s;
    logic [LINE_SIZE-1:0] res_data_s;
    logic                 unused_s;

    assign unused_s  = ^{mem_req_addr[OFF-1:0], mem_write_addr[OFF-1:0]};

    assign done_s    = (state_r != IDLE) && (lat_r == LAT_ZERO);
    assign can_acc_s = (state_r == IDLE) || done_s;

    // A read already parked or in flight for the same line is absorbed silently.
    assign rd_merge_s = mem_req &&
        ((pend_rd_v_r && (line_idx(mem_req_addr) == line_idx(pend_rd_addr_r))) ||
         ((state_r == RD) && (line_idx(mem_req_addr) == line_idx(op_addr_r))));
    assign rd_in_s    = mem_req && !rd_merge_s;

    // Source selection for the single service slot, writes ahead of reads.
    always_comb begin
        if (!can_acc_s) begin
            src_s = SRC_NONE;
        end else if (pend_wr_v_r) begin
            src_s = SRC_PWR;
        end else if (mem_write) begin
            src_s = SRC_WR;
        end else if (pend_rd_v_r) begin
            src_s = SRC_PRD;
        end else if (rd_in_s) begin
            src_s = SRC_RD;
        end else begin
            src_s = SRC_NONE;
        end
    end

    // A slot being drained into service this cycle can take a new request at once.
    assign wr_park_s = mem_write && (src_s != SRC_WR) && (!pend_wr_v_r || (src_s == SRC_PWR));
    assign wr_drop_s = mem_write && (src_s != SRC_WR) && pend_wr_v_r && (src_s != SRC_PWR);
    assign rd_park_s = rd_in_s && (src_s != SRC_RD) && (!pend_rd_v_r || (src_s == SRC_PRD));
    assign rd_drop_s = rd_in_s && (src_s != SRC_RD) && pend_rd_v_r && (src_s != SRC_PRD);
    assign err_nxt_s = err_r | wr_drop_s | rd_drop_s;

    // FSM next state, latency counter and in-service operation.
    always_comb begin
        state_nxt_s   = state_r;
        lat_nxt_s     = lat_r;
        op_addr_nxt_s = op_addr_r;
        op_data_nxt_s = op_data_r;
        case (src_s)
            SRC_PWR: begin
                state_nxt_s   = WR;
                lat_nxt_s     = LAT_INIT;
                op_addr_nxt_s = pend_wr_addr_r;
                op_data_nxt_s = pend_wr_data_r;
            end
            SRC_WR: begin
                state_nxt_s   = WR;
                lat_nxt_s     = LAT_INIT;
                op_addr_nxt_s = line_align(mem_write_addr);
                op_data_nxt_s = mem_write_data;
            end
            SRC_PRD: begin
                state_nxt_s   = RD;
                lat_nxt_s     = LAT_INIT;
                op_addr_nxt_s = pend_rd_addr_r;
            end
            SRC_RD: begin
                state_nxt_s   = RD;
                lat_nxt_s     = LAT_INIT;
                op_addr_nxt_s = line_align(mem_req_addr);
            end
            default: begin
                if (done_s) begin
                    state_nxt_s = IDLE;
                end else if (state_r != IDLE) begin
                    lat_nxt_s = lat_r - LAT_W'(1);
                end else begin
                    state_nxt_s = IDLE;
                end
            end
        endcase
    end

    // Pending write slot.
    always_comb begin
        if (wr_park_s) begin
            pend_wr_v_nxt_s    = 1'b1;
            pend_wr_addr_nxt_s = line_align(mem_write_addr);
            pend_wr_data_nxt_s = mem_write_data;
        end else if (src_s == SRC_PWR) begin
            pend_wr_v_nxt_s    = 1'b0;
            pend_wr_addr_nxt_s = pend_wr_addr_r;
            pend_wr_data_nxt_s = pend_wr_data_r;
        end else begin
            pend_wr_v_nxt_s    = pend_wr_v_r;
            pend_wr_addr_nxt_s = pend_wr_addr_r;
            pend_wr_data_nxt_s = pend_wr_data_r;
        end
    end

    // Pending read slot.
    always_comb begin
        if (rd_park_s) begin
            pend_rd_v_nxt_s    = 1'b1;
            pend_rd_addr_nxt_s = line_align(mem_req_addr);
        end else if (src_s == SRC_PRD) begin
            pend_rd_v_nxt_s    = 1'b0;
            pend_rd_addr_nxt_s = pend_rd_addr_r;
        end else begin
            pend_rd_v_nxt_s    = pend_rd_v_r;
            pend_rd_addr_nxt_s = pend_rd_addr_r;
        end
    end

    // The response register loads on the edge entering a read's completion cycle, so a
    // write retiring on that same edge must be forwarded.
    assign wr_commit_s = (state_r == WR) && done_s;
    assign res_fire_s  = (state_nxt_s == RD) && (lat_nxt_s == LAT_ZERO);
    assign res_data_s  = (wr_commit_s && (line_idx(op_addr_r) == line_idx(op_addr_nxt_s)))
                       ? op_data_r : mem_r[line_idx(op_addr_nxt_s)];

    // Line array; an aborted write never reaches it.
    always_ff @(posedge clk) begin
        if (rst && wr_commit_s) begin
            mem_r[line_idx(op_addr_r)] <= op_data_r;
        end
    end

    // Control, pending slots and response registers.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r        <= IDLE;
            lat_r          <= LAT_ZERO;
            op_addr_r      <= {WORD_SIZE{1'b0}};
            op_data_r      <= {LINE_SIZE{1'b0}};
            pend_rd_v_r    <= 1'b0;
            pend_rd_addr_r <= {WORD_SIZE{1'b0}};
            pend_wr_v_r    <= 1'b0;
            pend_wr_addr_r <= {WORD_SIZE{1'b0}};
            pend_wr_data_r <= {LINE_SIZE{1'b0}};
            err_r          <= 1'b0;
            mem_res_r      <= 1'b0;
            mem_res_addr_r <= {WORD_SIZE{1'b0}};
            mem_res_data_r <= {LINE_SIZE{1'b0}};
        end else begin
            state_r        <= state_nxt_s;
            lat_r          <= lat_nxt_s;
            op_addr_r      <= op_addr_nxt_s;
            op_data_r      <= op_data_nxt_s;
            pend_rd_v_r    <= pend_rd_v_nxt_s;
            pend_rd_addr_r <= pend_rd_addr_nxt_s;
            pend_wr_v_r    <= pend_wr_v_nxt_s;
            pend_wr_addr_r <= pend_wr_addr_nxt_s;
            pend_wr_data_r <= pend_wr_data_nxt_s;
            err_r          <= err_nxt_s;
            mem_res_r      <= res_fire_s;
            if (res_fire_s) begin
                mem_res_addr_r <= op_addr_nxt_s;
                mem_res_data_r <= res_data_s;
            end
        end
    end

    assign mem_res      = mem_res_r;
    assign mem_res_addr = mem_res_addr_r;
    assign mem_res_data = mem_res_data_r;
    assign busy         = (state_r != IDLE);
    assign err          = err_r;

`ifdef DMEM_CTRL_STATS_EN
    logic [31:0] rd_count_r;
    logic [31:0] wr_count_r;

    // Completion counters, free-running modulo 2^32.
    always_ff @(posedge clk) begin
        if (!rst) begin
            rd_count_r <= 32'd0;
            wr_count_r <= 32'd0;
        end else begin
            if ((state_r == RD) && done_s) begin
                rd_count_r <= rd_count_r + 32'd1;
            end
            if (wr_commit_s) begin
                wr_count_r <= wr_count_r + 32'd1;
            end
        end
    end

    assign rd_count = rd_count_r;
    assign wr_count = wr_count_r;
`endif

endmodule

// File: tb/tb_dmem_ctrl.sv
// Directed bench for dmem_ctrl: a cycle-scheduled transaction model predicts every output
// each cycle, and literal expectations pin the key scenarios.
module tb_dmem_ctrl;

    localparam int LAT     = 5;
    localparam int END_CYC = 88;
    localparam logic [127:0] DAT_A = {4{32'hAAAA_AAAA}};
    localparam logic [127:0] DAT_D = {4{32'h1234_5678}};
    localparam logic [127:0] DAT_B = {4{32'hBBBB_0001}};
    localparam logic [127:0] DAT_C = {4{32'hCCCC_0002}};
    localparam logic [127:0] DAT_E = {4{32'hDDDD_0003}};

    logic         clk = 1'b0;
    logic         rst;
    logic         mem_req;
    logic [31:0]  mem_req_addr;
    logic         mem_write;
    logic [31:0]  mem_write_addr;
    logic [127:0] mem_write_data;
    logic         mem_res;
    logic [31:0]  mem_res_addr;
    logic [127:0] mem_res_data;
    logic         busy;
    logic         err;
`ifdef DMEM_CTRL_STATS_EN
    logic [31:0]  rd_count;
    logic [31:0]  wr_count;
`endif

    always #5 clk = ~clk;

    dmem_ctrl #(.WORD_SIZE(32), .LINE_SIZE(128), .MEM_LINES(256), .MEM_LATENCY(LAT)) dut (
        .clk(clk), .rst(rst),
        .mem_req(mem_req), .mem_req_addr(mem_req_addr),
        .mem_write(mem_write), .mem_write_addr(mem_write_addr), .mem_write_data(mem_write_data),
        .mem_res(mem_res), .mem_res_addr(mem_res_addr), .mem_res_data(mem_res_data),
        .busy(busy), .err(err)
`ifdef DMEM_CTRL_STATS_EN
        , .rd_count(rd_count), .wr_count(wr_count)
`endif
    );

    int n_vec = 0;
    int n_bad = 0;

    // Transaction-level model: one operation with an absolute completion edge number,
    // plus at most one parked read and one parked write.
    logic [127:0] mdl_mem [256];
    bit           op_v, op_wr, prd_v, pwr_v;
    logic [31:0]  op_addr, prd_addr, pwr_addr;
    logic [127:0] op_data, pwr_data;
    int           op_done;
    bit           exp_busy, exp_res, exp_err;
    logic [31:0]  exp_res_addr;
    logic [127:0] exp_res_data;
    int           m_rd_cnt, m_wr_cnt;

    function automatic int midx(input logic [31:0] a);
        return int'((a / 32'd16) % 32'd256);
    endfunction

    function automatic logic [31:0] malign(input logic [31:0] a);
        return a - (a % 32'd16);
    endfunction

    task automatic chk(input string name, input int cyc, input logic [127:0] act,
                       input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s cycle %0d: got %h want %h", name, cyc, act, exp);
        end
    endtask

    task automatic start_op(input bit wr, input logic [31:0] a, input logic [127:0] d,
                            input int e);
        op_v    = 1'b1;
        op_wr   = wr;
        op_addr = malign(a);
        op_data = d;
        op_done = e + LAT;
    endtask

    // Advance the model across edge e using the inputs of cycle e.
    task automatic model_step(input int e);
        bit merged, wr_in, rd_in;
        if (!rst) begin
            op_v = 1'b0; prd_v = 1'b0; pwr_v = 1'b0; exp_err = 1'b0;
            exp_res = 1'b0; exp_res_addr = 32'd0; exp_res_data = 128'd0;
            m_rd_cnt = 0; m_wr_cnt = 0;
        end else begin
            merged = mem_req && ((prd_v && midx(mem_req_addr) == midx(prd_addr)) ||
                                 (op_v && !op_wr && midx(mem_req_addr) == midx(op_addr)));
            if (op_v && op_done == e) begin
                if (op_wr) begin
                    mdl_mem[midx(op_addr)] = op_data;
                    m_wr_cnt++;
                end else begin
                    m_rd_cnt++;
                end
                op_v = 1'b0;
            end
            wr_in = mem_write;
            rd_in = mem_req && !merged;
            if (!op_v) begin
                if (pwr_v) begin
                    start_op(1'b1, pwr_addr, pwr_data, e); pwr_v = 1'b0;
                end else if (wr_in) begin
                    start_op(1'b1, mem_write_addr, mem_write_data, e); wr_in = 1'b0;
                end else if (prd_v) begin
                    start_op(1'b0, prd_addr, 128'd0, e); prd_v = 1'b0;
                end else if (rd_in) begin
                    start_op(1'b0, mem_req_addr, 128'd0, e); rd_in = 1'b0;
                end
            end
            if (wr_in) begin
                if (pwr_v) exp_err = 1'b1;
                else begin pwr_v = 1'b1; pwr_addr = mem_write_addr; pwr_data = mem_write_data; end
            end
            if (rd_in) begin
                if (prd_v) exp_err = 1'b1;
                else begin prd_v = 1'b1; prd_addr = mem_req_addr; end
            end
            exp_res = op_v && !op_wr && (op_done == e + 1);
            if (exp_res) begin
                exp_res_addr = op_addr;
                exp_res_data = mdl_mem[midx(op_addr)];
            end
        end
        exp_busy = op_v;
    endtask

    task automatic set_inputs(input int c);
        rst = 1'b1; mem_req = 1'b0; mem_req_addr = 32'd0;
        mem_write = 1'b0; mem_write_addr = 32'd0; mem_write_data = 128'd0;
        case (c)
            1, 2, 48: rst = 1'b0;
            3:  begin mem_req = 1'b1; mem_req_addr = 32'h40; end
            10: begin mem_write = 1'b1; mem_write_addr = 32'h80; mem_write_data = DAT_A;
                      mem_req = 1'b1; mem_req_addr = 32'h8C; end
            22: begin mem_req = 1'b1; mem_req_addr = 32'h00; end
            23: begin mem_req = 1'b1; mem_req_addr = 32'h10; end
            34: begin mem_req = 1'b1; mem_req_addr = 32'h30; end
            35, 36: begin mem_req = 1'b1; mem_req_addr = 32'h10; end
            37: begin mem_req = 1'b1; mem_req_addr = 32'h20; end
            46: begin mem_write = 1'b1; mem_write_addr = 32'h100; mem_write_data = DAT_D; end
            50: begin mem_req = 1'b1; mem_req_addr = 32'h100; end
            57: begin mem_write = 1'b1; mem_write_addr = 32'h1010; mem_write_data = DAT_B; end
            58: begin mem_req = 1'b1; mem_req_addr = 32'h10; end
            63: begin mem_write = 1'b1; mem_write_addr = 32'h20; mem_write_data = DAT_C; end
            64: begin mem_write = 1'b1; mem_write_addr = 32'h30; mem_write_data = DAT_E; end
            70: begin mem_req = 1'b1; mem_req_addr = 32'h20; end
            79: begin mem_req = 1'b1; mem_req_addr = 32'h30; end
            default: ;
        endcase
    endtask

    task automatic check_cycle(input int c);
        chk("busy", c, busy, exp_busy);
        chk("mem_res", c, mem_res, exp_res);
        chk("mem_res_addr", c, mem_res_addr, exp_res_addr);
        chk("mem_res_data", c, mem_res_data, exp_res_data);
        chk("err", c, err, exp_err);
`ifdef DMEM_CTRL_STATS_EN
        chk("rd_count", c, rd_count, m_rd_cnt);
        chk("wr_count", c, wr_count, m_wr_cnt);
        if (c == 49) begin chk("lit_rd_count_rst", c, rd_count, 32'd0);
                           chk("lit_wr_count_rst", c, wr_count, 32'd0); end
        if (c == 78) begin chk("lit_rd_count", c, rd_count, 32'd3);
                           chk("lit_wr_count", c, wr_count, 32'd2); end
`endif
        case (c)
            4:  chk("lit_busy_first", c, busy, 1'b1);
            7:  chk("lit_no_early_res", c, mem_res, 1'b0);
            8:  begin chk("lit_res_first", c, mem_res, 1'b1);
                      chk("lit_addr_first", c, mem_res_addr, 32'h40);
                      chk("lit_data_first", c, mem_res_data, 128'd0); end
            9:  chk("lit_idle_after", c, busy, 1'b0);
            20: begin chk("lit_res_evict", c, mem_res, 1'b1);
                      chk("lit_addr_evict", c, mem_res_addr, 32'h80);
                      chk("lit_data_evict", c, mem_res_data, DAT_A); end
            21: chk("lit_err_clean", c, err, 1'b0);
            27: begin chk("lit_res_b2b0", c, mem_res, 1'b1);
                      chk("lit_addr_b2b0", c, mem_res_addr, 32'h00); end
            28: begin chk("lit_no_bubble", c, busy, 1'b1);
                      chk("lit_res_pulse", c, mem_res, 1'b0); end
            32: begin chk("lit_res_b2b1", c, mem_res, 1'b1);
                      chk("lit_addr_b2b1", c, mem_res_addr, 32'h10); end
            37: chk("lit_merge_no_err", c, err, 1'b0);
            38: chk("lit_overflow_err", c, err, 1'b1);
            49: begin chk("lit_err_reset", c, err, 1'b0);
                      chk("lit_busy_reset", c, busy, 1'b0); end
            55: begin chk("lit_res_abort", c, mem_res, 1'b1);
                      chk("lit_addr_abort", c, mem_res_addr, 32'h100);
                      chk("lit_data_abort", c, mem_res_data, 128'd0); end
            65: chk("lit_wr_overflow", c, err, 1'b1);
            67: begin chk("lit_addr_alias", c, mem_res_addr, 32'h10);
                      chk("lit_data_alias", c, mem_res_data, DAT_B); end
            77: begin chk("lit_res_pendwr", c, mem_res, 1'b1);
                      chk("lit_data_pendwr", c, mem_res_data, DAT_C); end
            84: begin chk("lit_addr_dropwr", c, mem_res_addr, 32'h30);
                      chk("lit_data_dropwr", c, mem_res_data, 128'd0); end
            default: ;
        endcase
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mdl_mem[i] = 128'd0;
        op_v = 1'b0; op_wr = 1'b0; prd_v = 1'b0; pwr_v = 1'b0; op_done = 0;
        op_addr = 32'd0; prd_addr = 32'd0; pwr_addr = 32'd0;
        op_data = 128'd0; pwr_data = 128'd0;
        exp_busy = 1'b0; exp_res = 1'b0; exp_err = 1'b0;
        exp_res_addr = 32'd0; exp_res_data = 128'd0; m_rd_cnt = 0; m_wr_cnt = 0;
        for (int c = 1; c <= END_CYC; c++) begin
            set_inputs(c);
            if (c > 1) begin
                @(negedge clk);
                check_cycle(c);
            end
            model_step(c);
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        check_cycle(END_CYC + 1);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/dmem_ctrl.md
Name: dmem_ctrl

Overview:
- Main-memory controller directly downstream of the data-cache stage.
- Consumes the stage's line-fill requests (mem_req/mem_req_addr) and dirty-line writebacks (mem_write/mem_write_addr/mem_write_data).
- Returns fills on mem_res/mem_res_addr/mem_res_data after a fixed latency.
- Single-ported line array: one operation in service at a time, plus one pending slot each for read and write.

Parameters:
- WORD_SIZE, 32, address/word width.
- LINE_SIZE, 128, cache line width in bits.
- MEM_LINES, 256, number of lines in the backing array; power of 2.
- MEM_LATENCY, 5, cycles from acceptance to completion; must be >= 1.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous reset, active-low: sampled at clk edge, reset when 0.
- mem_req  in  1  line read request, single-cycle pulse.
- mem_req_addr  in  WORD_SIZE  read byte address.
- mem_write  in  1  line writeback request, single-cycle pulse.
- mem_write_addr  in  WORD_SIZE  writeback byte address.
- mem_write_data  in  LINE_SIZE  writeback line.
- mem_res  out  1  read response valid, one-cycle pulse.
- mem_res_addr  out  WORD_SIZE  line-aligned address of the response.
- mem_res_data  out  LINE_SIZE  line data.
- busy  out  1  an operation is in service.
- err  out  1  sticky: a request was dropped because its pending slot was occupied.

Behaviour:
- Line index = addr[OFF +: log2(MEM_LINES)], where OFF = log2(LINE_SIZE/8). Offset bits are ignored. mem_res_addr has the offset bits zeroed.
- Reset (rst=0 at an edge):
  - mem_res=0, mem_res_addr=0, mem_res_data=0, busy=0, err=0.
  - FSM goes to IDLE; pending slots are cleared; latency counter = 0.
  - An in-service read yields no response. An in-service write is discarded, not committed.
  - Array contents are not reset; they are zero at time 0.
- FSM states:
  - IDLE: no operation in service.
  - RD: read in service, lat_cnt counting.
  - WR: write in service, lat_cnt counting.
  - busy = (state != IDLE).
- Acceptance: occurs in IDLE, or in the completion cycle of RD/WR (no bubble). Source priority:
  1. pending write
  2. incoming mem_write
  3. pending read
  4. incoming mem_req
- Any unaccepted incoming request that cycle goes into its pending slot. If that slot is already full, the request is dropped and err is set to 1 (sticky until reset).
- Exception: a read whose line index equals the pending or in-service read's index is merged (ignored) and does not set err.
- Simultaneous mem_write and mem_req in IDLE: the write is accepted; the read goes to the pending read slot. The read therefore observes the written line (eviction-then-fill ordering).
- Latency counting: an operation accepted at the edge ending cycle N sets lat_cnt = MEM_LATENCY-1. lat_cnt decrements each cycle. Completion is the cycle with lat_cnt==0, which is cycle N+MEM_LATENCY.
- Read completion: mem_res=1 for exactly that cycle, with registered mem_res_addr and mem_res_data (array content at completion). mem_res is 0 in all other cycles; mem_res_data holds its last value.
- Write completion: the array line is updated at the completion edge. There is no response.
- Then go to IDLE, or directly into RD/WR if another operation is accepted in the same cycle.
- Address wrap: addresses above MEM_LINES*LINE_SIZE/8 alias modulo the array size. No error is raised.

Optional Feature:
- Macro: DMEM_CTRL_STATS_EN.
- When defined, two extra outputs exist:
  - rd_count (32-bit): +1 per read completion.
  - wr_count (32-bit): +1 per write completion.
  - Both reset to 0 and wrap at 2^32.
- When undefined, these ports and counters do not exist. All other behaviour is identical.

Test Plan:
- Reset with rst=0 for 2 cycles, then mem_req addr 0x40 in cycle 3 → mem_res=1 only in cycle 3+5=8, mem_res_addr=0x40, data=0. busy=1 in cycles 4-8.
- mem_write addr 0x80 data 0xAAAA...A plus mem_req addr 0x8C in the same cycle N → write completes at N+5. mem_res in cycle N+10 with addr 0x80, data 0xAAAA...A. err=0.
- Back-to-back: two reads 0x00 then 0x10, in cycles N and N+1 → responses in cycles N+5 and N+10, no bubble.
- Overflow: while a read is in service and a read is pending (0x10), issue a read to 0x20 → 0x20 is dropped and err=1 until reset. A duplicate read to 0x10 does not set err.
- Reset mid-write: write 0x100 accepted, rst=0 two cycles later → a subsequent read of 0x100 returns the old data (0). No mem_res for the aborted operation.
- With DMEM_CTRL_STATS_EN, 3 reads + 2 writes → rd_count=3, wr_count=2. After reset both are 0.
